// File: rtl/avg_mag_ref_level.sv
// Decision-directed reference-level estimator: averages |dec_var| over one LFSR period
// and derives the expected mapper power 1.25*ref^2. Optional macro: AVG_MAG_SAM_GATE_EN.
module avg_mag_ref_level #(
    parameter int ACC_WID  = 40,
    parameter int LFSR_WID = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic               clr_acc,
    input  logic signed [17:0] dec_var,
    output logic signed [17:0] ref_lvl,
    output logic signed [17:0] map_out_pwr
);

    logic               acc_en;
    logic [17:0]        neg_dv;
    logic [16:0]        mag;
    logic [ACC_WID:0]   sum;
    logic [ACC_WID-1:0] sat_sum;
    logic [ACC_WID-1:0] avg;
    logic [16:0]        avg_sat;

    logic [ACC_WID-1:0] acc_q, acc_d;
    logic [16:0]        ref_q, ref_d;
    logic [33:0]        sq;
    logic [17:0]        p_q;
    logic [18:0]        pw;
    logic [16:0]        pwr_q;

`ifdef AVG_MAG_SAM_GATE_EN
    assign acc_en = sym_clk_en & sam_clk_en;
`else
    logic unused_sam;
    assign unused_sam = sam_clk_en;
    assign acc_en     = sym_clk_en;
`endif

    // Full-scale negative input has no positive 17-bit twin; clamp it to the max magnitude.
    assign neg_dv = 18'(-dec_var);
    assign mag    = !dec_var[17]          ? dec_var[16:0] :
                    (dec_var[16:0] == '0) ? 17'h1FFFF     : neg_dv[16:0];

    assign sum     = {1'b0, acc_q} + {{(ACC_WID-16){1'b0}}, mag};
    assign sat_sum = sum[ACC_WID] ? '1 : sum[ACC_WID-1:0];
    assign avg     = sat_sum >> LFSR_WID;
    assign avg_sat = (|avg[ACC_WID-1:17]) ? 17'h1FFFF : avg[16:0];

    always_comb begin
        acc_d = acc_q;
        ref_d = ref_q;
        if (acc_en) begin
            if (clr_acc) begin
                ref_d = avg_sat;
                acc_d = '0;
            end else begin
                acc_d = sat_sum;
            end
        end
    end

    assign sq = {17'd0, ref_q} * {17'd0, ref_q};
    assign pw = {1'b0, p_q} + {3'd0, p_q[17:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ref_q <= '0;
            p_q   <= '0;
            pwr_q <= '0;
        end else begin
            acc_q <= acc_d;
            ref_q <= ref_d;
            p_q   <= sq[33:16];
            pwr_q <= (|pw[18:17]) ? 17'h1FFFF : pw[16:0];
        end
    end

    assign ref_lvl     = {1'b0, ref_q};
    assign map_out_pwr = {1'b0, pwr_q};

endmodule

// File: tb/tb_avg_mag_ref_level.sv
// Randomized/directed bench for avg_mag_ref_level: two instances (ACC_WID 20 and 40,
// LFSR_WID 4) compared every clock against an arithmetic reference model.
module tb_avg_mag_ref_level;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic reset, sam, sym, clr;
    logic signed [17:0] dv;
    logic signed [17:0] ref_a, pwr_a, ref_b, pwr_b;

    int n_chk = 0;
    int n_err = 0;

    longint amax [2];
    longint m_acc[2], m_ref[2], m_r1[2], m_r2[2];

    always #5 clk = ~clk;

    avg_mag_ref_level #(.ACC_WID(20), .LFSR_WID(LW)) u_a (
        .clk(clk), .reset(reset), .sam_clk_en(sam), .sym_clk_en(sym), .clr_acc(clr),
        .dec_var(dv), .ref_lvl(ref_a), .map_out_pwr(pwr_a));

    avg_mag_ref_level #(.ACC_WID(40), .LFSR_WID(LW)) u_b (
        .clk(clk), .reset(reset), .sam_clk_en(sam), .sym_clk_en(sym), .clr_acc(clr),
        .dec_var(dv), .ref_lvl(ref_b), .map_out_pwr(pwr_b));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint f_mag(input longint v);
        if (v == -131072) return 131071;
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint f_pwr(input longint r);
        longint p, s;
        p = (r * r) / 65536;
        s = p + p / 4;
        return (s > 131071) ? 131071 : s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_ref[c] = 0; m_r1[c] = 0; m_r2[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit     q;
        longint s;
`ifdef AVG_MAG_SAM_GATE_EN
        q = sym && sam;
`else
        q = sym;
`endif
        for (int c = 0; c < 2; c++) begin
            m_r2[c] = m_r1[c];
            m_r1[c] = m_ref[c];
            if (q) begin
                s = m_acc[c] + f_mag(longint'(dv));
                if (s > amax[c]) s = amax[c];
                if (clr) begin
                    m_ref[c] = (s / 16 > 131071) ? 131071 : s / 16;
                    m_acc[c] = 0;
                end else begin
                    m_acc[c] = s;
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("ref_a", longint'(ref_a), m_ref[0]);
        chk("pwr_a", longint'(pwr_a), f_pwr(m_r2[0]));
        chk("ref_b", longint'(ref_b), m_ref[1]);
        chk("pwr_b", longint'(pwr_b), f_pwr(m_r2[1]));
    endtask

    // Called right after a falling edge; drives, clocks, then checks on the next falling edge.
    task automatic step(input logic signed [17:0] v, input bit s_en, input bit c, input bit sm);
        dv = v; sym = s_en; clr = c; sam = sm;
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++)
            step(18'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    endtask

    // kind: 0 = +0.5, 1 = -0.5, 2 = alternating levels, 3 = negative full scale
    task automatic period(input int kind, input int first, input int last);
        logic signed [17:0] v;
        for (int i = first; i <= last; i++) begin
            case (kind)
                0: v = 18'sd32768;
                1: v = -18'sd32768;
                2: case (i % 4)
                       0: v = 18'sd16384;
                       1: v = -18'sd49152;
                       2: v = -18'sd16384;
                       default: v = 18'sd49152;
                   endcase
                default: v = -18'sd131072;
            endcase
            step(v, 1'b1, i == 15, 1'b1);
            idle(1);
        end
        idle(3);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("arst_ref", longint'(ref_b), 0);
        chk("arst_pwr", longint'(pwr_b), 0);
        idle(3);
        reset = 1'b0;
    endtask

    initial begin
        amax[0] = (64'd1 << 20) - 1;
        amax[1] = (64'd1 << 40) - 1;
        model_reset();
        reset = 1'b1; sam = 1'b0; sym = 1'b0; clr = 1'b0; dv = '0;

        for (int i = 0; i < 20; i++) begin
            sym = 1'($urandom); clr = 1'($urandom); sam = 1'($urandom); dv = 18'($urandom);
            @(negedge clk);
            chk("rst_ref", longint'(ref_a), 0);
            chk("rst_pwr", longint'(pwr_b), 0);
        end
        reset = 1'b0;

        period(0, 0, 15);
        chk("pos_ref", longint'(ref_a), 32768);
        chk("pos_pwr", longint'(pwr_a), 20480);

        period(1, 0, 15);
        chk("neg_ref", longint'(ref_b), 32768);
        chk("neg_pwr", longint'(pwr_b), 20480);

        period(2, 0, 15);
        chk("alt_ref", longint'(ref_a), 32768);

        period(3, 0, 15);
        chk("sat_ref_a", longint'(ref_a), 65535);
        chk("sat_ref_b", longint'(ref_b), 131071);
        chk("sat_pwr_b", longint'(pwr_b), 131071);

        // clr_acc while sym_clk_en is low must neither publish nor clear
        period(0, 0, 7);
        for (int j = 0; j < 4; j++) step(-18'sd131072, 1'b0, 1'b1, 1'b1);
        chk("gate_ref", longint'(ref_b), 131071);
        period(0, 8, 15);
        chk("gate_avg", longint'(ref_a), 32768);

        period(3, 0, 6);
        async_reset();
        period(0, 0, 15);
        chk("rst_mid_ref", longint'(ref_b), 32768);
        chk("rst_mid_pwr", longint'(pwr_b), 20480);

        for (int i = 0; i < 400; i++) begin
            logic signed [17:0] v;
            v = 18'($urandom);
            if ($urandom_range(0, 9) == 0) v = -18'sd131072;
            step(v, ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
